// File: rtl/program_loader.sv
// Byte-stream program loader: assembles little-endian words from a
// length-prefixed stream and writes them through the core debug port.
module program_loader #(
  parameter int XLEN = 64,
  parameter int INSTRUCTION_LENGTH = XLEN / 2,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int MAX_WORDS = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_byte,
  output logic                          in_ready,
  input  logic                          load_start,
  output logic                          dbg_wr_en,
  output logic [XLEN-1:0]               dbg_addr,
  output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
  output logic                          core_rst,
  output logic                          load_done,
  output logic                          load_err
);

  localparam logic [2:0] HDR0  = 3'd0;
  localparam logic [2:0] HDR1  = 3'd1;
  localparam logic [2:0] WORD  = 3'd2;
  localparam logic [2:0] SETUP = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] RUN   = 3'd5;
  localparam logic [2:0] ERR   = 3'd6;

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] n_q, n_d;
  logic [15:0] hdr;
  logic        xfer;

  logic [INSTRUCTION_LENGTH-1:0] word_q, word_d;
  logic [INSTRUCTION_LENGTH-1:0] instr_q, instr_d;
  logic [XLEN-1:0]               addr_q, addr_d;

  logic wr_en_q, core_rst_q, done_q, err_q;

  assign in_ready = !rst &&
    (state_q == HDR0 || state_q == HDR1 ||
     state_q == WORD);

  assign xfer = in_valid && in_ready;
  assign hdr  = {in_byte, n_q[7:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    n_d     = n_q;
    word_d  = word_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    case (state_q)
      HDR0: begin
        if (xfer) begin
          n_d[7:0] = in_byte;
          state_d  = HDR1;
        end
      end
      HDR1: begin
        if (xfer) begin
          n_d[15:8] = in_byte;
          if (hdr == 16'd0) begin
            state_d = RUN;
          end else if ({1'b0, hdr} > MAXW) begin
            state_d = ERR;
          end else begin
            state_d = WORD;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      WORD: begin
        if (xfer) begin
          word_d[{cnt_q, 3'b000} +: 8] = in_byte;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = SETUP;
            // Address wraps naturally at XLEN bits.
            addr_d  = BASE_ADDR +
                      (XLEN'(idx_q) << 2);
            instr_d = word_d;
          end
        end
      end
      SETUP: begin
        state_d = WRITE;
      end
      WRITE: begin
        if (idx_q == n_q - 16'd1) begin
          state_d = RUN;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = WORD;
        end
      end
      RUN, ERR: begin
        if (load_start) begin
          state_d = HDR0;
        end
      end
      default: begin
        state_d = HDR0;
      end
    endcase
  end

  // Status outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HDR0;
      cnt_q      <= '0;
      idx_q      <= '0;
      n_q        <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      instr_q    <= '0;
      wr_en_q    <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      wr_en_q    <= (state_d == WRITE);
      core_rst_q <= (state_d != RUN);
      done_q     <= (state_d == RUN);
      err_q      <= (state_d == ERR);
    end
  end

  assign dbg_wr_en = wr_en_q;
  assign dbg_addr  = addr_q;
  assign dbg_instr = instr_q;
  assign core_rst  = core_rst_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with a word-level model;
// a second instance runs the same stream with BASE_ADDR = 0x100.
module tb_program_loader;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst, in_valid, load_start;
  logic [7:0] in_byte;

  logic        in_ready, dbg_wr_en, core_rst;
  logic        load_done, load_err;
  logic [63:0] dbg_addr;
  logic [31:0] dbg_instr;

  logic        in_ready_b, dbg_wr_en_b, core_rst_b;
  logic        load_done_b, load_err_b;
  logic [63:0] dbg_addr_b;
  logic [31:0] dbg_instr_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cyc = -1;

  logic [63:0] wa[$];
  logic [31:0] wi[$];
  int          wc[$];
  bit          ws[$];
  logic [63:0] wb[$];
  logic [31:0] wbi[$];
  logic        prev_done = 1'b0;
  logic [63:0] prev_addr = '0;
  logic [31:0] prev_instr = '0;

  logic [63:0] ea[$];
  logic [63:0] eb[$];
  logic [31:0] ei[$];

  program_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .load_start(load_start),
    .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr),
    .dbg_instr(dbg_instr), .core_rst(core_rst),
    .load_done(load_done), .load_err(load_err)
  );

  program_loader #(.BASE_ADDR(64'h100)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready_b), .load_start(load_start),
    .dbg_wr_en(dbg_wr_en_b), .dbg_addr(dbg_addr_b),
    .dbg_instr(dbg_instr_b), .core_rst(core_rst_b),
    .load_done(load_done_b), .load_err(load_err_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dbg_wr_en) begin
      wa.push_back(dbg_addr);
      wi.push_back(dbg_instr);
      wc.push_back(cyc);
      ws.push_back(dbg_addr == prev_addr &&
                   dbg_instr == prev_instr);
    end
    if (dbg_wr_en_b) begin
      wb.push_back(dbg_addr_b);
      wbi.push_back(dbg_instr_b);
    end
    if (load_done && !prev_done) done_cyc = cyc;
    prev_done  = load_done;
    prev_addr  = dbg_addr;
    prev_instr = dbg_instr;
  end

  task automatic clear_log();
    wa.delete(); wi.delete(); wc.delete();
    ws.delete(); wb.delete(); wbi.delete();
    ea.delete(); eb.delete(); ei.delete();
    done_cyc = -1;
  endtask

  // Reference: word i is bytes 2+4i..2+4i+3, little-endian.
  task automatic build_model(input bq_t bs);
    int n;
    n = int'({bs[1], bs[0]});
    for (int i = 0; i < n; i++) begin
      ei.push_back({bs[2+4*i+3], bs[2+4*i+2],
                    bs[2+4*i+1], bs[2+4*i]});
      ea.push_back(64'(4 * i));
      eb.push_back(64'h100 + 64'(4 * i));
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      g++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_byte timeout in_ready=%0b want 1",
               in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_byte  = 8'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_all(input bq_t bs, input int gmax);
    foreach (bs[i]) send_byte(bs[i], $urandom_range(gmax, 0));
  endtask

  task automatic wait_done(input int lim);
    int g;
    g = 0;
    while (!load_done && g < lim) begin
      @(posedge clk); #1;
      g++;
    end
    tests++;
    if (!load_done) begin
      fails++;
      $display("FAIL wait_done timeout load_done=%0b want 1",
               load_done);
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_byte = 8'h5a;
    load_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, dbg_wr_en, core_rst, load_done, load_err}
        !== 5'b00100) begin
      fails++;
      $display("FAIL reset_flags got %b want 00100",
        {in_ready, dbg_wr_en, core_rst, load_done, load_err});
    end
    tests++;
    if (dbg_addr !== 64'd0 || dbg_instr !== 32'd0) begin
      fails++;
      $display("FAIL reset_regs addr=%h instr=%h want 0",
               dbg_addr, dbg_instr);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_two_word();
    bq_t bs;
    bs = '{8'h02, 8'h00, 8'h13, 8'h80, 8'h10, 8'h00,
           8'h93, 8'h20, 8'h11, 8'h00};
    clear_log();
    send_all(bs, 0);
    wait_done(20);
    tests++;
    if (wa.size() != 2) begin
      fails++;
      $display("FAIL two_count got %0d want 2", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 64'd0 || wi[0] !== 32'h00108013) begin
        fails++;
        $display("FAIL two_w0 got %h/%h want 0/00108013",
                 wa[0], wi[0]);
      end
      tests++;
      if (wa[1] !== 64'd4 || wi[1] !== 32'h00112093) begin
        fails++;
        $display("FAIL two_w1 got %h/%h want 4/00112093",
                 wa[1], wi[1]);
      end
      tests++;
      if (wc[1] - wc[0] != 6) begin
        fails++;
        $display("FAIL two_spacing got %0d want 6",
                 wc[1] - wc[0]);
      end
      tests++;
      if (done_cyc != wc[1] + 1) begin
        fails++;
        $display("FAIL two_release got %0d want %0d",
                 done_cyc, wc[1] + 1);
      end
      tests++;
      if (!ws[0] || !ws[1]) begin
        fails++;
        $display("FAIL two_stable got %b%b want 11",
                 ws[0], ws[1]);
      end
    end
    tests++;
    if (core_rst !== 1'b0 || load_done !== 1'b1) begin
      fails++;
      $display("FAIL two_run core_rst=%b done=%b want 0/1",
               core_rst, load_done);
    end
  endtask

  task automatic test_run_ignores();
    clear_log();
    in_valid = 1'b1;
    in_byte = 8'hff;
    repeat (4) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL run_ready got %b want 0", in_ready);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (wa.size() != 0 || load_done !== 1'b1) begin
      fails++;
      $display("FAIL run_idle strobes=%0d done=%b want 0/1",
               wa.size(), load_done);
    end
  endtask

  task automatic test_restart();
    clear_log();
    pulse_start();
    tests++;
    if ({core_rst, load_done, in_ready} !== 3'b101) begin
      fails++;
      $display("FAIL restart_flags got %b want 101",
               {core_rst, load_done, in_ready});
    end
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h73, 0);
    load_start = 1'b1;
    send_byte(8'h00, 0);
    load_start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_done(20);
    tests++;
    if (wa.size() != 1) begin
      fails++;
      $display("FAIL restart_count got %0d want 1", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 64'd0 || wi[0] !== 32'h00000073) begin
        fails++;
        $display("FAIL restart_w0 got %h/%h want 0/00000073",
                 wa[0], wi[0]);
      end
    end
  endtask

  task automatic test_throttled();
    bq_t bs;
    bs = '{8'h02, 8'h00, 8'h13, 8'h80, 8'h10, 8'h00,
           8'h93, 8'h20, 8'h11, 8'h00};
    clear_log();
    build_model(bs);
    pulse_start();
    foreach (bs[i]) send_byte(bs[i], 1);
    wait_done(20);
    tests++;
    if (wa.size() != ea.size()) begin
      fails++;
      $display("FAIL thr_count got %0d want %0d",
               wa.size(), ea.size());
    end else begin
      foreach (ea[i]) begin
        tests++;
        if (wa[i] !== ea[i] || wi[i] !== ei[i]) begin
          fails++;
          $display("FAIL thr_w%0d got %h/%h want %h/%h",
                   i, wa[i], wi[i], ea[i], ei[i]);
        end
      end
    end
  endtask

  task automatic test_empty();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    tests++;
    if (load_done !== 1'b1 || core_rst !== 1'b0) begin
      fails++;
      $display("FAIL empty_run done=%b core_rst=%b want 1/0",
               load_done, core_rst);
    end
    @(negedge clk);
    tests++;
    if (wa.size() != 0) begin
      fails++;
      $display("FAIL empty_strobe got %0d want 0", wa.size());
    end
  endtask

  task automatic test_oversize();
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    tests++;
    if ({load_err, core_rst, in_ready, load_done}
        !== 4'b1100) begin
      fails++;
      $display("FAIL over_err got %b want 1100",
               {load_err, core_rst, in_ready, load_done});
    end
    pulse_start();
    tests++;
    if ({load_err, core_rst, in_ready} !== 3'b011) begin
      fails++;
      $display("FAIL over_restart got %b want 011",
               {load_err, core_rst, in_ready});
    end
  endtask

  task automatic test_reset_mid_word();
    clear_log();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h80, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b0 || core_rst !== 1'b1) begin
      fails++;
      $display("FAIL midrst_flags ready=%b core_rst=%b want 0/1",
               in_ready, core_rst);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (wa.size() != 0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_idle strobes=%0d ready=%b want 0/1",
               wa.size(), in_ready);
    end
    @(posedge clk); #1;
    send_all('{8'h01, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd}, 0);
    wait_done(20);
    tests++;
    if (wa.size() != 1) begin
      fails++;
      $display("FAIL midrst_count got %0d want 1", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 64'd0 || wi[0] !== 32'hddccbbaa) begin
        fails++;
        $display("FAIL midrst_w0 got %h/%h want 0/ddccbbaa",
                 wa[0], wi[0]);
      end
    end
  endtask

  task automatic test_random(input int nmin, input int nmax,
                             input int rounds);
    bq_t bs;
    int n;
    for (int r = 0; r < rounds; r++) begin
      clear_log();
      n = $urandom_range(nmax, nmin);
      bs.delete();
      bs.push_back(8'(n));
      bs.push_back(8'(n >> 8));
      for (int k = 0; k < 4 * n; k++) bs.push_back(8'($urandom));
      build_model(bs);
      pulse_start();
      send_all(bs, 2);
      wait_done(40);
      tests++;
      if (wa.size() != ea.size() || wb.size() != eb.size()) begin
        fails++;
        $display("FAIL rnd%0d_count got %0d/%0d want %0d",
                 r, wa.size(), wb.size(), ea.size());
      end else begin
        foreach (ea[i]) begin
          tests++;
          if (wa[i] !== ea[i] || wi[i] !== ei[i] ||
              wb[i] !== eb[i] || wbi[i] !== ei[i] || !ws[i]) begin
            fails++;
            $display("FAIL rnd%0d_w%0d got %h/%h/%h want %h/%h/%h",
                     r, i, wa[i], wb[i], wi[i],
                     ea[i], eb[i], ei[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_run_ignores();
    test_restart();
    test_throttled();
    test_empty();
    test_oversize();
    test_reset_mid_word();
    test_random(3, 3, 1);
    test_random(1, 6, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
